// File: rtl/rv_pkg.sv
// rv_pkg: definitions shared by the integer register file and its scoreboard.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   REG_ZERO             : the hardwired-zero register address
//   rf_state_e           : clear-engine states (RF_INIT, RF_READY)
package rv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [0:0] {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write busy bits for the register file.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset (clears all bits)
//   set_en, set_addr     mark a register as having a write in flight
//   clr_en, clr_addr     a writeback has landed for this register
//   look_addr            NRD packed lookup addresses, port k at [k*AW +: AW]
//   look_busy            busy bit for each lookup port (address 0 reads 0)
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] look_addr,
  output logic [NRD-1:0]    look_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // The set is applied after the clear so that a new issue to a register
  // whose previous writer is retiring this cycle keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_look
    logic [AW-1:0] addr;
    assign addr         = look_addr[k*AW +: AW];
    assign look_busy[k] = (addr == AW'(REG_ZERO)) ? 1'b0 : busy[addr];
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port integer register file with a
// pending-write scoreboard and a post-reset clear engine.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   init_done    high once every register has been zeroed
//   rd_addr      NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data      NRD packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy      per-port "register has a write pending"
//   iss_valid    an instruction writing iss_rd is being issued
//   iss_rd       destination register of that instruction
//   wb_we, wb_addr, wb_data  writeback port
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle forwarding of
// the writeback value (and busy release) to matching read ports.
module reg_file_mp
  import rv_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                wb_we,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data
);

  // No reset on storage so it can map onto distributed RAM.
  logic [XLEN-1:0] regs [NREGS];

  rf_state_e     state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic          done_next;
  logic          clear_we;
  logic          ready;

  logic          wb_ok;
  logic          iss_ok;
  logic [NRD-1:0] sb_busy;

  assign ready  = (state == RF_READY);
  assign wb_ok  = ready && wb_we && (wb_addr != AW'(REG_ZERO));
  assign iss_ok = ready && iss_valid && (iss_rd != AW'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RF_INIT;
      ptr       <= AW'(1);
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      init_done <= done_next;
    end
  end

  // Clear engine: one register per cycle starting at 1 (register 0 is never
  // stored); finishing the last register moves to READY for good.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    done_next  = init_done;
    clear_we   = 1'b0;
    if (state == RF_INIT) begin
      clear_we = 1'b1;
      ptr_next = ptr + AW'(1);
      if (ptr == AW'(NREGS - 1)) begin
        state_next = RF_READY;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clear_we)   regs[ptr]     <= '0;
      else if (wb_ok) regs[wb_addr] <= wb_data;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (iss_ok),
    .set_addr  (iss_rd),
    .clr_en    (wb_ok),
    .clr_addr  (wb_addr),
    .look_addr (rd_addr),
    .look_busy (sb_busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    assign hit = wb_we && (wb_addr == addr);
`else
    assign hit = 1'b0;
`endif

    // While clearing, and for register 0, ports read as zero and idle. A
    // forwarded write releases busy unless the same register is re-issued.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (ready && (addr != AW'(REG_ZERO))) begin
        if (hit) begin
          data = wb_data;
          busy = iss_valid && (iss_rd == addr);
        end else begin
          data = regs[addr];
          busy = sb_busy[k];
        end
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: self-checking bench for reg_file_mp (NRD=4, 32x32).
// A behavioural model tracks register contents, busy bits and clear
// progress; a negedge process compares every port against it, and directed
// sequences pin specific literal values.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 4;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                init_done;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  // Behavioural model: a counter of edges since reset decides when the file
  // is ready; once ready, every register is zero and updates follow the
  // write/issue rules (a later issue to the same register wins).
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_ready = 1'b0;
  int              m_cnt   = 0;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_ready <= 1'b0;
      m_cnt   <= 0;
      for (int i = 0; i < NREGS; i++) m_busy[i] <= 1'b0;
    end else if (!m_ready) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == NREGS - 1) begin
        m_ready <= 1'b1;
        for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
      end
    end else begin
      if (wb_we && wb_addr != 0) begin
        m_regs[wb_addr] <= wb_data;
        m_busy[wb_addr] <= 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compareModel();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] ed;
    logic            eb;
    checkOutput("model_init_done", 32'(init_done), 32'(m_ready));
    for (int k = 0; k < NRD; k++) begin
      a  = rd_addr[k*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (m_ready && a != 0) begin
        ed = m_regs[a];
        eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && wb_addr == a) begin
          ed = wb_data;
          eb = iss_valid && (iss_rd == a);
        end
`endif
      end
      checkOutput($sformatf("model_rd_data[%0d]", k), rd_data[k*XLEN +: XLEN], ed);
      checkOutput($sformatf("model_rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(eb));
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) compareModel();
  end

  // Drive one cycle's inputs, let one rising edge capture them.
  task automatic applyStimulus(input logic r, input logic iv, input logic [AW-1:0] ird,
                               input logic we, input logic [AW-1:0] wa,
                               input logic [XLEN-1:0] wd, input logic [NRD*AW-1:0] ad);
    rst_n     = r;
    iss_valid = iv;
    iss_rd    = ird;
    wb_we     = we;
    wb_addr   = wa;
    wb_data   = wd;
    rd_addr   = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle(input logic [AW-1:0] a);
    rst_n     = 1'b1;
    iss_valid = 1'b0;
    wb_we     = 1'b0;
    rd_addr   = {NRD{a}};
    #1;
  endtask

  task automatic waitInit(input string name, input bit inject);
    int n    = 0;
    bit done = 1'b0;
    while (!done && n < 100) begin
      if (inject && n == 3)
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, {NRD{5'd5}});
      else
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, {NRD{5'd5}});
      n++;
      if (init_done === 1'b1) done = 1'b1;
    end
    checkOutput(name, 32'(n), 32'd31);
  endtask

  logic [NRD*AW-1:0] raddr;

  initial begin
    rst_n     = 1'b0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    rd_addr   = '0;

    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, '0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, '0);
    checkOutput("reset_init_done", 32'(init_done), 32'h0);
    checkOutput("reset_busy", 32'(rd_busy), 32'h0);

    waitInit("init_latency", 1'b1);

    for (int r = 1; r < NREGS; r++) begin
      setIdle(AW'(r));
      checkOutput($sformatf("cleared_reg%0d", r), rd_data[XLEN-1:0], 32'h0);
    end
    setIdle(5'd5);
    checkOutput("init_write_dropped", rd_data[XLEN-1:0], 32'h0);
    checkOutput("init_issue_dropped", 32'(rd_busy), 32'h0);

    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678, {NRD{5'd7}});
    setIdle(5'd7);
    for (int k = 0; k < NRD; k++)
      checkOutput($sformatf("reg7_port%0d", k), rd_data[k*XLEN +: XLEN], 32'h12345678);

    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, '0);
    setIdle(5'd0);
    checkOutput("reg0_stays_zero", rd_data[XLEN-1:0], 32'h0);

    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, {NRD{5'd3}});
    setIdle(5'd3);
    checkOutput("issue3_busy", 32'(rd_busy), 32'hF);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'hA5, {NRD{5'd3}});
    setIdle(5'd3);
    checkOutput("wb3_busy", 32'(rd_busy), 32'h0);
    checkOutput("wb3_data", rd_data[XLEN-1:0], 32'hA5);

    applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, {NRD{5'd9}});
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, {NRD{5'd9}});
    setIdle(5'd9);
    checkOutput("collision9_busy", 32'(rd_busy[0]), 32'h1);
    checkOutput("collision9_data", rd_data[XLEN-1:0], 32'h99);

    applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, {NRD{5'd4}});
    rst_n     = 1'b1;
    iss_valid = 1'b0;
    wb_we     = 1'b1;
    wb_addr   = 5'd4;
    wb_data   = 32'h55;
    rd_addr   = {NRD{5'd4}};
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_same_data", rd_data[2*XLEN +: XLEN], 32'h55);
    checkOutput("bypass_same_busy", 32'(rd_busy[2]), 32'h0);
`else
    checkOutput("nobypass_same_data", rd_data[2*XLEN +: XLEN], 32'h0);
    checkOutput("nobypass_same_busy", 32'(rd_busy[2]), 32'h1);
`endif
    @(posedge clk);
    #1;
    setIdle(5'd4);
    checkOutput("write4_next_data", rd_data[2*XLEN +: XLEN], 32'h55);
    checkOutput("write4_next_busy", 32'(rd_busy[2]), 32'h0);

    // Small address range to provoke collisions between ports, issue and writeback.
    repeat (600) begin
      for (int k = 0; k < NRD; k++) raddr[k*AW +: AW] = AW'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 7)), $urandom, raddr);
    end

    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, '0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, '0);
    waitInit("reinit_latency", 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 32'h0, {NRD{5'd12}});
    setIdle(5'd12);
    checkOutput("issue12_busy", 32'(rd_busy), 32'hF);

    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, '0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, '0);
    repeat (10) applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, {NRD{5'd12}});
    checkOutput("midinit_not_done", 32'(init_done), 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, '0);
    waitInit("midinit_latency", 1'b0);
    setIdle(5'd12);
    checkOutput("midinit_busy_cleared", 32'(rd_busy), 32'h0);
    checkOutput("midinit_data_cleared", rd_data[XLEN-1:0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
